// File: rtl/fsm_event_logger_if.sv
// Event delivery handshake between the logger (master) and its consumer (slave).
interface fsm_event_logger_if;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic [7:0] ev_stamp;
    logic       ev_ready;

    modport master (output ev_valid, ev_code, ev_stamp, input ev_ready);
    modport slave  (input ev_valid, ev_code, ev_stamp, output ev_ready);
endinterface

// File: rtl/fsm_event_logger.sv
// Logs sequence-detector codes as time-stamped events into a small FIFO and
// keeps saturating per-code counts plus a sticky overflow flag.
module fsm_event_logger #(
    parameter  int DEPTH = 4,
    parameter  int CW    = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              code,
    input  logic                    clr,
    fsm_event_logger_if.master      ev,
    output logic [CW-1:0]           cnt1,
    output logic [CW-1:0]           cnt2,
    output logic [CW-1:0]           cnt3,
    output logic [AW:0]             level,
    output logic                    ovf
);

    typedef struct packed {
        logic [1:0] code;
        logic [7:0] stamp;
    } evt_t;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [7:0]          stamp_q;
    logic [AW-1:0]       wptr, rptr;
    logic [AW:0]         level_q;
    logic                ovf_q;
    logic [3:1][CW-1:0]  cnt_q;
    evt_t                mem [DEPTH];

    logic ev_in, full, valid, pop, push, drop;

    always_comb begin
        ev_in = (code != 2'b00);
        valid = (level_q != '0);
        full  = (level_q == FULL_LVL);
        pop   = valid && ev.ev_ready;
        // A full FIFO still accepts when the head leaves on the same edge.
        push  = ev_in && (!full || pop);
        drop  = ev_in && full && !pop;
    end

    // Stamp free-runs through clr so timestamps stay comparable across clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stamp_q <= '0;
        else      stamp_q <= stamp_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wptr] <= '{code: code, stamp: stamp_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else if (clr) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
            if (drop) ovf_q <= 1'b1;
        end
    end

    for (genvar i = 1; i <= 3; i++) begin : g_cnt
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                cnt_q[i] <= '0;
            else if (clr)
                cnt_q[i] <= '0;
            else if (code == 2'(i) && cnt_q[i] != {CW{1'b1}})
                cnt_q[i] <= cnt_q[i] + CW'(1);
        end
    end

    // Outputs come only from registers; empty FIFO presents zeros.
    assign ev.ev_valid = valid;
    assign ev.ev_code  = valid ? mem[rptr].code  : 2'b00;
    assign ev.ev_stamp = valid ? mem[rptr].stamp : 8'd0;
    assign cnt1  = cnt_q[1];
    assign cnt2  = cnt_q[2];
    assign cnt3  = cnt_q[3];
    assign level = level_q;
    assign ovf   = ovf_q;

endmodule
